ppad_access_sched: RTL and testbench
====================================

// Module: ppad_access_sched
// PURPOSE
//  Scheduler for the single-read/single-write partial-sum pad (PPad) inside one PE path.
//  - Sequences a pad-clear pass, then shares the read port between the MAIN accumulate reader and the PS drain reader.
//  - Gates the SS writer and the PS reader against each other so neither overruns the other.
//  - Produces the registered pad control word and per-requester read-data valid strobes.
// PARAMETERS
//  PPADDEPTH  32  pad entries; AW = $clog2(PPADDEPTH)
//  STARVEMAX  4   consecutive PS-denied cycles before PS wins the read port
// PORTS
//  i_clk          in   1      clock
//  i_rst          in   1      synchronous reset, active-high
//  i_start        in   1      pulse: begin pass (ignored unless IDLE)
//  i_size         in   AW+1   live entries this pass, 1..PPADDEPTH; sampled on i_start
//  i_abort        in   1      return to IDLE next cycle from any state
//  MAIN_rdy       in   1      MAIN read request
//  MAIN_ack       out  1      MAIN read granted (same cycle)
//  i_main_raddr   in   AW     MAIN read address
//  PS_rdy         in   1      PS drain read request
//  PS_ack         out  1      PS read granted (same cycle)
//  SS_rdy         in   1      SS write request
//  SS_ack         out  1      SS write granted (same cycle)
//  i_ss_waddr     in   AW     SS write address
//  o_read         out  1      pad read enable (registered)
//  o_raddr        out  AW     pad read address (registered)
//  o_write        out  1      pad write enable (registered)
//  o_waddr        out  AW     pad write address (registered)
//  o_wzero        out  1      write data is zero, i.e. clear pass (registered)
//  o_rv_main      out  1      pad read data belongs to MAIN (1 cycle after o_read)
//  o_rv_ps        out  1      pad read data belongs to PS (1 cycle after o_read)
//  o_ps_raddr     out  AW     current PS drain index
//  o_done         out  1      1-cycle pulse when last PS read is acked
// BEHAVIOUR
//  Reset: FSM IDLE; every output 0; internal counters and high-water mark 0; size register 1.
//  FSM states:
//   IDLE: i_start -> CLEAR.
//   CLEAR: writes 0..size-1 with o_wzero=1, one entry per cycle; all acks 0.
//    After the last write -> RUN.
//   RUN: normal arbitration; PS drain index runs 0..size-1.
//    PS ack with index==size-1 -> o_done pulse next cycle, then IDLE.
//   i_abort wins over every transition. Acks are 0 in the i_abort cycle.
//  Write port (RUN only): SS_ack = SS_rdy && !(ps_ahead && i_ss_waddr < ps_idx).
//   SS may not rewrite an entry PS has already drained.
//  Read arbitration (RUN only):
//   - MAIN has priority.
//   - PS wins when starve_cnt==STARVEMAX. starve_cnt counts cycles with PS_rdy high and PS not acked; it clears on PS ack.
//   - PS is eligible only while ps_idx < hwm. hwm = highest SS write address acked this pass, +1, saturating at size.
//   - Read-during-write hazard: a candidate read whose address equals this cycle's granted SS write address is not acked.
//    The other requester may take the port instead.
//   - At most one read ack per cycle; PS ack increments ps_idx.
//  Latency: ack combinational. o_read/o_raddr/o_write/o_waddr register the granted request (+1 cycle).
//   o_rv_* follow o_read by one more cycle (+2 from ack).
//  ps_ahead sets when ps_idx wraps past the first SS address 0 write of the pass, mirroring PS/SS address priority.
//  Width: hwm and ps_idx are AW+1 bits; compares unsigned. i_size=PPADDEPTH must not overflow.
//  Simultaneous: i_start while not IDLE is ignored; abort and start in the same cycle -> abort.
// STRUCTURE
//  PECfg package: PPctl-compatible control typedef and the enum { IDLE, CLEAR, RUN }.
//  Sub-module: reuse LoopCounterD1 for both the clear counter and the PS drain index.
//  The arbiter stays inline.
// TESTING
//  1. i_start, i_size=4 -> o_write, o_wzero high for 4 cycles on addr 0..3; then RUN, acks enabled.
//  2. RUN, MAIN_rdy and PS_rdy held, SS has written 0..3 -> MAIN acked 4 cycles; PS acked on 5th (STARVEMAX=4).
//  3. PS_rdy, no SS write yet (hwm=0) -> PS_ack=0. SS writes addr 0 -> PS acked next cycle, o_ps_raddr=0.
//  4. SS writes addr 2 while MAIN reads addr 2 -> MAIN_ack=0 that cycle; MAIN acked the following cycle.
//  5. Size 4, PS drains 0..3 -> o_done pulses 1 cycle after 4th PS ack; state IDLE; o_rv_ps 2 cycles after each ack.
//  6. i_abort mid-CLEAR at addr 1 -> no write next cycle; IDLE; i_start relaunches clear from addr 0.

Source files
------------

// File: rtl/ppad_access_sched_pkg.sv
// Shared types and constants for the partial-sum pad access scheduler.
//  ppad_state_e : scheduler phase (IDLE, CLEAR, RUN)
//  ppad_ctl_t   : registered pad control word (read/write port command)
//  hwm_bump     : high-water-mark update for one acked SS write
package ppad_access_sched_pkg;

  localparam int unsigned PPADDEPTH      = 32;
  localparam int unsigned PPAD_AW        = $clog2(PPADDEPTH);
  localparam int unsigned PPAD_CW        = PPAD_AW + 1;
  localparam int unsigned PPAD_STARVEMAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } ppad_state_e;

  typedef struct packed {
    logic               read;
    logic [PPAD_AW-1:0] raddr;
    logic               write;
    logic [PPAD_AW-1:0] waddr;
    logic               wzero;
  } ppad_ctl_t;

  // New high-water mark after an SS write to waddr: max(hwm, min(waddr+1, size)).
  function automatic logic [PPAD_CW-1:0] hwm_bump(input logic [PPAD_CW-1:0] hwm,
                                                  input logic [PPAD_AW-1:0] waddr,
                                                  input logic [PPAD_CW-1:0] size);
    logic [PPAD_CW-1:0] nxt;
    nxt = PPAD_CW'(waddr) + PPAD_CW'(1);
    if (nxt > size) nxt = size;
    return (nxt > hwm) ? nxt : hwm;
  endfunction

endpackage

// File: rtl/ppad_access_sched_loopcnt.sv
// Index counter used for the clear sweep and the PS drain index.
//  i_clk, i_rst : clock, synchronous active-high reset
//  i_clr        : force count to 0 (wins over i_inc)
//  i_inc        : advance count by one
//  o_cnt        : current count (registered)
module ppad_access_sched_loopcnt #(
  parameter int unsigned W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/ppad_access_sched.sv
// Access scheduler for the single-read/single-write partial-sum pad.
// Runs a zero-fill pass over the live entries, then arbitrates the read
// port between MAIN (priority) and the PS drain reader, and gates the SS
// writer against the PS reader.
//  i_clk, i_rst            : clock, synchronous active-high reset
//  i_start, i_size         : launch a pass of i_size entries (IDLE only)
//  i_abort                 : return to IDLE, suppress this cycle's grants
//  MAIN_rdy/ack, i_main_raddr : MAIN read request / same-cycle grant
//  PS_rdy/ack              : PS drain read request / same-cycle grant
//  SS_rdy/ack, i_ss_waddr  : SS write request / same-cycle grant
//  o_read/o_raddr, o_write/o_waddr/o_wzero : registered pad control
//  o_rv_main, o_rv_ps      : read-data owner strobes, one cycle after o_read
//  o_ps_raddr              : current PS drain index
//  o_done                  : pulse the cycle after the last PS grant
module ppad_access_sched
  import ppad_access_sched_pkg::*;
#(
  parameter int unsigned STARVEMAX = PPAD_STARVEMAX
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [PPAD_AW:0]   i_size,
  input  logic               i_abort,
  input  logic               MAIN_rdy,
  output logic               MAIN_ack,
  input  logic [PPAD_AW-1:0] i_main_raddr,
  input  logic               PS_rdy,
  output logic               PS_ack,
  input  logic               SS_rdy,
  output logic               SS_ack,
  input  logic [PPAD_AW-1:0] i_ss_waddr,
  output logic               o_read,
  output logic [PPAD_AW-1:0] o_raddr,
  output logic               o_write,
  output logic [PPAD_AW-1:0] o_waddr,
  output logic               o_wzero,
  output logic               o_rv_main,
  output logic               o_rv_ps,
  output logic [PPAD_AW-1:0] o_ps_raddr,
  output logic               o_done
);

  localparam int unsigned AW = PPAD_AW;
  localparam int unsigned CW = PPAD_CW;
  localparam int unsigned SW = $clog2(STARVEMAX + 1);

  ppad_state_e   state_q, state_d;
  logic [CW-1:0] size_q, size_d;
  ppad_ctl_t     ctl_q, ctl_d;
  logic          rd_main_q, rd_main_d;
  logic          rd_ps_q, rd_ps_d;
  logic          rv_main_q, rv_main_d;
  logic          rv_ps_q, rv_ps_d;
  logic          done_q, done_d;
  logic [CW-1:0] hwm_q, hwm_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ss0_q, ss0_d;
  logic          ps_ahead_q, ps_ahead_d;

  logic [CW-1:0] clr_cnt;
  logic [CW-1:0] ps_idx_q;
  logic          clr_inc_c;
  logic          main_ack_c, ps_ack_c, ss_ack_c;

  logic [CW-1:0] size_m1_c;
  logic          clr_last_c, ps_last_c;
  logic          ss_ok_c, main_ok_c, ps_ok_c, starved_c;

  // Clear sweep index: held at 0 outside CLEAR.
  ppad_access_sched_loopcnt #(.W(CW)) u_clr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q != CLEAR),
    .i_inc (clr_inc_c),
    .o_cnt (clr_cnt)
  );

  // PS drain index: restarts from 0 every pass.
  ppad_access_sched_loopcnt #(.W(CW)) u_ps_idx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q != RUN),
    .i_inc (ps_ack_c),
    .o_cnt (ps_idx_q)
  );

  assign size_m1_c  = size_q - CW'(1);
  assign clr_last_c = (clr_cnt == size_m1_c);
  assign ps_last_c  = (ps_idx_q == size_m1_c);
  assign starved_c  = (starve_q == SW'(STARVEMAX));

  // SS may not overwrite an entry PS has already drained once PS is ahead.
  assign ss_ok_c   = SS_rdy && !(ps_ahead_q && (CW'(i_ss_waddr) < ps_idx_q));
  // Reads colliding with this cycle's granted write address are held off.
  assign main_ok_c = MAIN_rdy && !(ss_ok_c && (i_main_raddr == i_ss_waddr));
  assign ps_ok_c   = PS_rdy && (ps_idx_q < hwm_q) &&
                     !(ss_ok_c && (ps_idx_q[AW-1:0] == i_ss_waddr));

  // Next state, grants and the next control word.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    ctl_d      = '0;
    rd_main_d  = 1'b0;
    rd_ps_d    = 1'b0;
    rv_main_d  = rd_main_q;
    rv_ps_d    = rd_ps_q;
    done_d     = 1'b0;
    hwm_d      = hwm_q;
    starve_d   = starve_q;
    ss0_d      = ss0_q;
    ps_ahead_d = ps_ahead_q;
    clr_inc_c  = 1'b0;
    main_ack_c = 1'b0;
    ps_ack_c   = 1'b0;
    ss_ack_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        hwm_d      = '0;
        starve_d   = '0;
        ss0_d      = 1'b0;
        ps_ahead_d = 1'b0;
        if (i_start) begin
          state_d = CLEAR;
          size_d  = i_size;
        end
      end

      CLEAR: begin
        hwm_d       = '0;
        starve_d    = '0;
        ss0_d       = 1'b0;
        ps_ahead_d  = 1'b0;
        clr_inc_c   = 1'b1;
        ctl_d.write = 1'b1;
        ctl_d.waddr = clr_cnt[AW-1:0];
        ctl_d.wzero = 1'b1;
        if (clr_last_c) state_d = RUN;
      end

      RUN: begin
        ss_ack_c = ss_ok_c;
        if (ps_ok_c && (starved_c || !main_ok_c)) begin
          ps_ack_c = 1'b1;
        end else if (main_ok_c) begin
          main_ack_c = 1'b1;
        end

        if (ss_ack_c) begin
          ctl_d.write = 1'b1;
          ctl_d.waddr = i_ss_waddr;
          hwm_d       = hwm_bump(hwm_q, i_ss_waddr, size_q);
          if (i_ss_waddr == '0) ss0_d = 1'b1;
        end

        if (main_ack_c) begin
          ctl_d.read  = 1'b1;
          ctl_d.raddr = i_main_raddr;
          rd_main_d   = 1'b1;
        end else if (ps_ack_c) begin
          ctl_d.read  = 1'b1;
          ctl_d.raddr = ps_idx_q[AW-1:0];
          rd_ps_d     = 1'b1;
        end

        if (ps_ack_c) begin
          starve_d = '0;
          // PS has moved past the point where SS began this pass.
          if (ss0_q || (ss_ack_c && (i_ss_waddr == '0))) ps_ahead_d = 1'b1;
          if (ps_last_c) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (PS_rdy && !starved_c) begin
          starve_d = starve_q + SW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (i_abort) begin
      state_d    = IDLE;
      size_d     = size_q;
      ctl_d      = '0;
      rd_main_d  = 1'b0;
      rd_ps_d    = 1'b0;
      done_d     = 1'b0;
      hwm_d      = '0;
      starve_d   = '0;
      ss0_d      = 1'b0;
      ps_ahead_d = 1'b0;
      clr_inc_c  = 1'b0;
      main_ack_c = 1'b0;
      ps_ack_c   = 1'b0;
      ss_ack_c   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      size_q     <= CW'(1);
      ctl_q      <= '0;
      rd_main_q  <= 1'b0;
      rd_ps_q    <= 1'b0;
      rv_main_q  <= 1'b0;
      rv_ps_q    <= 1'b0;
      done_q     <= 1'b0;
      hwm_q      <= '0;
      starve_q   <= '0;
      ss0_q      <= 1'b0;
      ps_ahead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      ctl_q      <= ctl_d;
      rd_main_q  <= rd_main_d;
      rd_ps_q    <= rd_ps_d;
      rv_main_q  <= rv_main_d;
      rv_ps_q    <= rv_ps_d;
      done_q     <= done_d;
      hwm_q      <= hwm_d;
      starve_q   <= starve_d;
      ss0_q      <= ss0_d;
      ps_ahead_q <= ps_ahead_d;
    end
  end

  assign MAIN_ack   = main_ack_c;
  assign PS_ack     = ps_ack_c;
  assign SS_ack     = ss_ack_c;
  assign o_read     = ctl_q.read;
  assign o_raddr    = ctl_q.raddr;
  assign o_write    = ctl_q.write;
  assign o_waddr    = ctl_q.waddr;
  assign o_wzero    = ctl_q.wzero;
  assign o_rv_main  = rv_main_q;
  assign o_rv_ps    = rv_ps_q;
  assign o_ps_raddr = ps_idx_q[AW-1:0];
  assign o_done     = done_q;

endmodule

// File: tb/tb_ppad_access_sched.sv
// Directed bench for ppad_access_sched: clear pass, arbitration, hazards,
// drain completion, abort and full-depth pass.
module tb_ppad_access_sched;
  import ppad_access_sched_pkg::*;

  localparam int unsigned AW = PPAD_AW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW:0]   i_size;
  logic          i_abort;
  logic          MAIN_rdy, MAIN_ack;
  logic [AW-1:0] i_main_raddr;
  logic          PS_rdy, PS_ack;
  logic          SS_rdy, SS_ack;
  logic [AW-1:0] i_ss_waddr;
  logic          o_read, o_write, o_wzero, o_rv_main, o_rv_ps, o_done;
  logic [AW-1:0] o_raddr, o_waddr, o_ps_raddr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  ppad_access_sched dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_size       (i_size),
    .i_abort      (i_abort),
    .MAIN_rdy     (MAIN_rdy),
    .MAIN_ack     (MAIN_ack),
    .i_main_raddr (i_main_raddr),
    .PS_rdy       (PS_rdy),
    .PS_ack       (PS_ack),
    .SS_rdy       (SS_rdy),
    .SS_ack       (SS_ack),
    .i_ss_waddr   (i_ss_waddr),
    .o_read       (o_read),
    .o_raddr      (o_raddr),
    .o_write      (o_write),
    .o_waddr      (o_waddr),
    .o_wzero      (o_wzero),
    .o_rv_main    (o_rv_main),
    .o_rv_ps      (o_rv_ps),
    .o_ps_raddr   (o_ps_raddr),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to the next cycle; inputs change 2 time units after the edge.
  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drv(input logic m, input logic [AW-1:0] ma, input logic p,
                     input logic s, input logic [AW-1:0] sa);
    MAIN_rdy     = m;
    i_main_raddr = ma;
    PS_rdy       = p;
    SS_rdy       = s;
    i_ss_waddr   = sa;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_size  = (AW+1)'(1);
    i_abort = 1'b0;
    drv(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (3) cyc();

    // Reset state, requests in IDLE are not granted.
    i_rst = 1'b0;
    drv(1'b1, '0, 1'b1, 1'b1, '0);
    #1;
    chk("rst_read",  32'(o_read), 0);
    chk("rst_write", 32'(o_write), 0);
    chk("rst_wzero", 32'(o_wzero), 0);
    chk("rst_rv",    32'({o_rv_main, o_rv_ps}), 0);
    chk("rst_psidx", 32'(o_ps_raddr), 0);
    chk("rst_done",  32'(o_done), 0);
    chk("idle_acks", 32'({MAIN_ack, PS_ack, SS_ack}), 0);

    // Clear pass of 4 entries.
    cyc();
    drv(1'b0, '0, 1'b0, 1'b0, '0);
    i_start = 1'b1;
    i_size  = (AW+1)'(4);
    #1;
    cyc();
    i_start = 1'b0;
    drv(1'b1, '0, 1'b1, 1'b1, AW'(1));
    #1;
    chk("clr0_acks",  32'({MAIN_ack, PS_ack, SS_ack}), 0);
    chk("clr0_write", 32'(o_write), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) drv(1'b0, '0, 1'b0, 1'b0, '0);
      #1;
      chk("clr_write", 32'(o_write), 1);
      chk("clr_waddr", 32'(o_waddr), 32'(k));
      chk("clr_wzero", 32'(o_wzero), 1);
      if (k < 3) chk("clr_acks", 32'({MAIN_ack, PS_ack, SS_ack}), 0);
    end

    // PS gated by empty high-water mark, released by SS write to 0.
    cyc(); drv(1'b0, '0, 1'b1, 1'b0, '0); #1;
    chk("hwm0_ps_ack", 32'(PS_ack), 0);
    chk("run_nowrite", 32'(o_write), 0);
    chk("run_wzero",   32'(o_wzero), 0);
    cyc(); drv(1'b0, '0, 1'b1, 1'b1, AW'(0)); #1;
    chk("ss0_ack",      32'(SS_ack), 1);
    chk("ss0_ps_ack",   32'(PS_ack), 0);
    cyc(); drv(1'b0, '0, 1'b1, 1'b0, '0); #1;
    chk("ps0_ack",      32'(PS_ack), 1);
    chk("ps0_idx",      32'(o_ps_raddr), 0);
    chk("ss0_write",    32'({o_write, o_wzero}), 32'h2);
    chk("ss0_waddr",    32'(o_waddr), 0);
    // SS may not rewrite an entry PS has drained.
    cyc(); drv(1'b0, '0, 1'b0, 1'b1, AW'(0)); #1;
    chk("ss_behind_ps", 32'(SS_ack), 0);
    chk("ps0_read",     32'(o_read), 1);
    chk("ps0_raddr",    32'(o_raddr), 0);
    chk("ps_idx1",      32'(o_ps_raddr), 1);
    cyc(); drv(1'b0, '0, 1'b0, 1'b1, AW'(1)); #1;
    chk("ss1_ack",      32'(SS_ack), 1);
    chk("ps0_rv",       32'(o_rv_ps), 1);
    chk("no_read",      32'(o_read), 0);
    cyc(); drv(1'b0, '0, 1'b0, 1'b1, AW'(2)); #1;
    chk("ss2_ack",      32'(SS_ack), 1);
    cyc(); drv(1'b0, '0, 1'b0, 1'b1, AW'(3)); #1;
    chk("ss3_ack",      32'(SS_ack), 1);

    // MAIN priority for 4 cycles, then starved PS wins.
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(1'b1, AW'(5 + i), 1'b1, 1'b0, '0); #1;
      chk("main_pri_ack", 32'(MAIN_ack), 1);
      chk("main_pri_ps",  32'(PS_ack), 0);
      if (i == 1) begin
        chk("main_read",  32'(o_read), 1);
        chk("main_raddr", 32'(o_raddr), 5);
      end
    end
    cyc(); drv(1'b1, AW'(9), 1'b1, 1'b0, '0); #1;
    chk("starve_ps_ack",   32'(PS_ack), 1);
    chk("starve_main_ack", 32'(MAIN_ack), 0);
    chk("starve_idx",      32'(o_ps_raddr), 1);
    cyc(); drv(1'b0, '0, 1'b0, 1'b0, '0); #1;
    chk("starve_read",  32'(o_read), 1);
    chk("starve_raddr", 32'(o_raddr), 1);
    chk("main_rv",      32'(o_rv_main), 1);
    chk("ps_idx2",      32'(o_ps_raddr), 2);
    cyc(); #1;
    chk("starve_rv_ps",   32'(o_rv_ps), 1);
    chk("starve_rv_main", 32'(o_rv_main), 0);

    // Read-during-write hazard on address 2.
    cyc(); drv(1'b1, AW'(2), 1'b0, 1'b1, AW'(2)); #1;
    chk("rdw_ss_ack",   32'(SS_ack), 1);
    chk("rdw_main_ack", 32'(MAIN_ack), 0);
    cyc(); drv(1'b1, AW'(2), 1'b0, 1'b0, '0); #1;
    chk("rdw_main_retry", 32'(MAIN_ack), 1);
    chk("rdw_write",      32'(o_write), 1);
    chk("rdw_waddr",      32'(o_waddr), 2);

    // Drain entries 2 and 3, then done.
    cyc(); drv(1'b0, '0, 1'b1, 1'b0, '0); #1;
    chk("drain2_ack",   32'(PS_ack), 1);
    chk("drain2_idx",   32'(o_ps_raddr), 2);
    chk("drain2_raddr", 32'({o_read, o_raddr}), 32'h22);
    cyc(); #1;
    chk("drain3_ack",   32'(PS_ack), 1);
    chk("drain3_idx",   32'(o_ps_raddr), 3);
    chk("drain3_done",  32'(o_done), 0);
    chk("drain3_rvm",   32'(o_rv_main), 1);
    cyc(); #1;
    chk("done_pulse",   32'(o_done), 1);
    chk("done_idle_ps", 32'(PS_ack), 0);
    chk("done_raddr",   32'({o_read, o_raddr}), 32'h23);
    chk("done_rv_ps",   32'(o_rv_ps), 1);

    // Full-depth pass, aborted at clear address 1.
    cyc(); drv(1'b0, '0, 1'b0, 1'b0, '0);
    i_start = 1'b1;
    i_size  = (AW+1)'(PPADDEPTH);
    #1;
    chk("done_clear",  32'(o_done), 0);
    chk("last_rv_ps",  32'(o_rv_ps), 1);
    chk("idle_read",   32'(o_read), 0);
    chk("idle_psidx",  32'(o_ps_raddr), 0);
    cyc(); i_start = 1'b0; #1;
    chk("clr32_first", 32'(o_write), 0);
    cyc(); i_abort = 1'b1; #1;
    chk("abort_prev_write", 32'(o_write), 1);
    chk("abort_prev_waddr", 32'(o_waddr), 0);
    // Abort together with start: abort wins.
    cyc(); i_start = 1'b1; i_size = (AW+1)'(3); #1;
    chk("abort_nowrite", 32'({o_write, o_wzero}), 0);
    cyc(); i_abort = 1'b0; i_size = (AW+1)'(PPADDEPTH); #1;
    chk("abort_start_idle", 32'(o_write), 0);
    // Start while in CLEAR is ignored.
    cyc(); i_size = (AW+1)'(2); #1;
    chk("relaunch_first", 32'(o_write), 0);
    for (int k = 0; k < 32; k++) begin
      cyc();
      i_start = 1'b0;
      if (k == 31) drv(1'b1, AW'(7), 1'b0, 1'b0, '0);
      #1;
      chk("clr32_write", 32'({o_write, o_wzero}), 32'h3);
      chk("clr32_waddr", 32'(o_waddr), 32'(k));
      if (k == 31) chk("clr32_run_main", 32'(MAIN_ack), 1);
    end

    // hwm reaches 32 without overflow.
    cyc(); drv(1'b0, '0, 1'b0, 1'b1, AW'(31)); #1;
    chk("ss31_ack",    32'(SS_ack), 1);
    chk("ss31_nowr",   32'(o_write), 0);
    chk("main7_raddr", 32'({o_read, o_raddr}), 32'h27);
    cyc(); drv(1'b0, '0, 1'b1, 1'b0, '0); #1;
    chk("hwm32_ps_ack", 32'(PS_ack), 1);
    chk("hwm32_idx",    32'(o_ps_raddr), 0);
    chk("ss31_waddr",   32'({o_write, o_waddr}), 32'h3F);
    cyc(); i_abort = 1'b1; #1;
    chk("abort_ps_ack", 32'(PS_ack), 0);
    chk("abort_raddr",  32'({o_read, o_raddr}), 32'h20);
    chk("abort_idx",    32'(o_ps_raddr), 1);
    cyc(); i_abort = 1'b0; #1;
    chk("post_abort_ps", 32'(PS_ack), 0);
    chk("post_abort_rd", 32'(o_read), 0);
    chk("post_abort_rv", 32'(o_rv_ps), 1);
    cyc(); drv(1'b0, '0, 1'b0, 1'b0, '0); #1;
    chk("idle_idx_clr", 32'(o_ps_raddr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
